// File: rtl/led7seg_scan_scheduler_if.sv
// Word handshake between the digit scheduler and the 74HC595 shift-register controller.
// master drives dat/vld and holds them until rdy; slave returns rdy.
interface led7seg_scan_scheduler_if;
    logic [15:0] dat;
    logic        vld;
    logic        rdy;

    modport master (output dat, output vld, input rdy);
    modport slave  (input dat, input vld, output rdy);
endinterface

// File: rtl/led7seg_scan_scheduler.sv
// 8-digit 7-seg scan scheduler with a double-buffered frame store; one word per slot tick, vld one cycle after tick.
// vld/dat are held until rdy; ticks arriving during a stall queue once, further ones set sticky overrun.
module led7seg_scan_scheduler #(
    parameter int TICK_DIV = 15625,
    parameter bit SEG_INV  = 1'b1,
    parameter bit DIG_INV  = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            wr_en,
    input  logic [2:0]                      wr_addr,
    input  logic [5:0]                      wr_data,
    input  logic                            commit,
    output logic                            commit_done,
    led7seg_scan_scheduler_if.master        disp,
    output logic [2:0]                      digit_idx,
    output logic                            frame_start,
    output logic                            overrun
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [5:0] BLANK = 6'b010000;

    typedef enum logic [1:0] {IDLE, WAIT_TICK, SEND} state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [5:0]  shadow_q [8];
    logic [5:0]  active_q [8];
    logic [15:0] dat_q;
    logic        vld_q;
    logic [2:0]  digit_idx_q;
    logic        pend_tick_q;
    logic        pend_commit_q;
    logic        commit_done_q;
    logic        frame_start_q;
    logic        overrun_q;

    logic        tick;
    logic        accept;
    logic        swap;
    logic [5:0]  cur;
    logic [7:0]  seg_raw;
    logic [7:0]  dig_raw;
    logic [15:0] word_d;

    function automatic logic [7:0] seg_lut(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_lut = 8'h3F;
            4'd1:    seg_lut = 8'h06;
            4'd2:    seg_lut = 8'h5B;
            4'd3:    seg_lut = 8'h4F;
            4'd4:    seg_lut = 8'h66;
            4'd5:    seg_lut = 8'h6D;
            4'd6:    seg_lut = 8'h7D;
            4'd7:    seg_lut = 8'h07;
            4'd8:    seg_lut = 8'h7F;
            4'd9:    seg_lut = 8'h6F;
            4'd10:   seg_lut = 8'h77;
            4'd11:   seg_lut = 8'h7C;
            4'd12:   seg_lut = 8'h39;
            4'd13:   seg_lut = 8'h5E;
            4'd14:   seg_lut = 8'h79;
            default: seg_lut = 8'h71;
        endcase
    endfunction

    // Counter is gated by enable so a stale terminal count cannot fire after disable.
    assign tick   = enable && (cnt_q == CW'(TICK_DIV - 1));
    assign accept = (state_q == SEND) && vld_q && disp.rdy;
    assign swap   = accept && (digit_idx_q == 3'd7) && pend_commit_q;

    always_comb begin
        cur     = active_q[digit_idx_q];
        seg_raw = cur[4] ? 8'h00 : (seg_lut(cur[3:0]) | {cur[5], 7'b0});
        dig_raw = 8'b1 << digit_idx_q;
        word_d  = {(SEG_INV ? ~seg_raw : seg_raw), (DIG_INV ? ~dig_raw : dig_raw)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!enable || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // The swap copies the pre-write shadow; a same-cycle write lands in shadow only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= BLANK;
                active_q[i] <= BLANK;
            end
        end else begin
            if (swap) begin
                for (int i = 0; i < 8; i++) active_q[i] <= shadow_q[i];
            end
            if (wr_en) shadow_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            dat_q         <= '0;
            vld_q         <= 1'b0;
            digit_idx_q   <= '0;
            pend_tick_q   <= 1'b0;
            pend_commit_q <= 1'b0;
            commit_done_q <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            commit_done_q <= 1'b0;
            frame_start_q <= 1'b0;

            // A commit in the swap cycle is for the following frame.
            if (swap)        pend_commit_q <= commit;
            else if (commit) pend_commit_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (enable) state_q <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (!enable) begin
                        pend_tick_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (tick || pend_tick_q) begin
                        pend_tick_q <= 1'b0;
                        dat_q       <= word_d;
                        vld_q       <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (tick) begin
                        if (pend_tick_q) overrun_q <= 1'b1;
                        pend_tick_q <= 1'b1;
                    end
                    if (accept) begin
                        vld_q       <= 1'b0;
                        digit_idx_q <= digit_idx_q + 3'd1;
                        if (digit_idx_q == 3'd0) frame_start_q <= 1'b1;
                        if (swap)                commit_done_q <= 1'b1;
                        if (enable) begin
                            state_q <= WAIT_TICK;
                        end else begin
                            pend_tick_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign disp.dat    = dat_q;
    assign disp.vld    = vld_q;
    assign digit_idx   = digit_idx_q;
    assign frame_start = frame_start_q;
    assign commit_done = commit_done_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_led7seg_scan_scheduler.sv
// Scoreboard bench for led7seg_scan_scheduler with TICK_DIV=4, SEG_INV=1, DIG_INV=0.
module tb_led7seg_scan_scheduler;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [5:0] wr_data;
    logic       commit;
    logic       commit_done;
    logic [2:0] digit_idx;
    logic       frame_start;
    logic       overrun;

    led7seg_scan_scheduler_if disp_if ();

    led7seg_scan_scheduler #(.TICK_DIV(TD), .SEG_INV(1'b1), .DIG_INV(1'b0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .commit_done(commit_done), .disp(disp_if),
        .digit_idx(digit_idx), .frame_start(frame_start), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [18:0] exp_q [$];
    logic [5:0]  m_shadow [8];
    logic [5:0]  m_active [8];
    int          push_idx;
    int          pushed;

    function automatic logic [15:0] enc(input logic [5:0] d, input int idx);
        logic [7:0] seg;
        logic [7:0] dig;
        case (d[3:0])
            4'd0: seg = 8'h3F;  4'd1: seg = 8'h06;  4'd2: seg = 8'h5B;  4'd3: seg = 8'h4F;
            4'd4: seg = 8'h66;  4'd5: seg = 8'h6D;  4'd6: seg = 8'h7D;  4'd7: seg = 8'h07;
            4'd8: seg = 8'h7F;  4'd9: seg = 8'h6F;  4'd10: seg = 8'h77; 4'd11: seg = 8'h7C;
            4'd12: seg = 8'h39; 4'd13: seg = 8'h5E; 4'd14: seg = 8'h79; default: seg = 8'h71;
        endcase
        if (d[4]) seg = 8'h00;
        else if (d[5]) seg = seg | 8'h80;
        dig = 8'h01 << idx;
        return {~seg, dig};
    endfunction

    task automatic push_word();
        exp_q.push_back({3'(push_idx), enc(m_active[push_idx], push_idx)});
        push_idx = (push_idx + 1) % 8;
        pushed++;
    endtask

    task automatic push_frame();
        repeat (8) push_word();
    endtask

    // Monitor: every accepted word is popped and compared; strobes checked the cycle after.
    int          acc_count = 0;
    int          cyc = 0;
    int          last_acc_cyc = -1;
    int          last_gap = 0;
    bit          spacing_on = 1'b0;
    bit          prev_acc = 1'b0;
    logic [2:0]  prev_idx = '0;
    int          cd_cnt = 0;
    bit          cd_bad = 1'b0;
    logic [18:0] e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last_acc_cyc = -1;
            prev_acc     = 1'b0;
        end else begin
            if (prev_acc) chk("frame_start", 32'(frame_start), 32'(prev_idx == 3'd0));
            if (commit_done) begin
                cd_cnt++;
                if (!(prev_acc && prev_idx == 3'd7)) cd_bad = 1'b1;
            end
            prev_acc = 1'b0;
            if (disp_if.vld && disp_if.rdy) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("dat", 32'(disp_if.dat), 32'(e[15:0]));
                    chk("digit_idx", 32'(digit_idx), 32'(e[18:16]));
                end
                if (last_acc_cyc >= 0) begin
                    last_gap = cyc - last_acc_cyc;
                    if (spacing_on) chk("slot_gap", 32'(last_gap), 32'(TD));
                end
                last_acc_cyc = cyc;
                acc_count++;
                prev_acc = 1'b1;
                prev_idx = digit_idx;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n);
        int b = 0;
        while (acc_count < n && b < 2000) begin
            step();
            b++;
        end
        chk("acc_count", 32'(acc_count), 32'(n));
    endtask

    task automatic wait_vld();
        int b = 0;
        while (!disp_if.vld && b < 50) begin
            step();
            b++;
        end
        chk("vld_timeout", 32'(disp_if.vld), 32'd1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [5:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        m_shadow[a] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d0;
        logic [2:0]  i0;
        int          b;

        rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
        disp_if.rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin m_shadow[i] = 6'h10; m_active[i] = 6'h10; end
        push_idx = 0; pushed = 0;
        step(); step();
        chk("rst_vld", 32'(disp_if.vld), 32'd0);
        chk("rst_dat", 32'(disp_if.dat), 32'd0);
        chk("rst_idx", 32'(digit_idx), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Blank frames, then a mid-frame commit that must wait for the boundary.
        rst = 1'b0; enable = 1'b1; spacing_on = 1'b1;
        push_frame(); push_frame();
        wait_acc(11);
        wr(3'd0, 6'h00);
        wr(3'd3, 6'h07);
        commit = 1'b1; step(); commit = 1'b0;
        chk("commit_early", 32'(cd_cnt), 32'd0);
        for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
        push_frame();
        wait_acc(24);
        chk("commit_cnt_a", 32'(cd_cnt), 32'd1);

        // Write and commit in the same cycle.
        push_frame();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 6'h28; commit = 1'b1;
        step();
        wr_en = 1'b0; commit = 1'b0;
        m_shadow[5] = 6'h28;
        for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
        push_frame();
        wait_acc(40);
        chk("commit_cnt_b", 32'(cd_cnt), 32'd2);

        // Write landing exactly in the swap cycle stays in shadow only.
        push_frame();
        wr(3'd1, 6'h02);
        commit = 1'b1; step(); commit = 1'b0;
        for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
        push_frame();
        b = 0;
        @(negedge clk);
        while (!(disp_if.vld && disp_if.rdy && digit_idx == 3'd7) && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk("swap_found", 32'(digit_idx), 32'd7);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 6'h09;
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_shadow[1] = 6'h09;
        wait_acc(56);
        chk("commit_cnt_c", 32'(cd_cnt), 32'd3);

        // Stall: word held, one pending tick, then overrun.
        spacing_on = 1'b0;
        disp_if.rdy = 1'b0;
        push_frame();
        wait_vld();
        d0 = disp_if.dat; i0 = digit_idx;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("stall_dat", 32'(disp_if.dat), 32'(d0));
            chk("stall_idx", 32'(digit_idx), 32'(i0));
            if (k == 4) chk("overrun_after_one", 32'(overrun), 32'd0);
            if (k == 9) chk("overrun_after_two", 32'(overrun), 32'd1);
        end
        disp_if.rdy = 1'b1;
        wait_acc(58);
        chk("pending_gap", 32'(last_gap), 32'd2);
        wait_acc(64);

        // Disable while a word is held.
        disp_if.rdy = 1'b0;
        push_word();
        wait_vld();
        enable = 1'b0;
        repeat (3) begin
            step();
            chk("hold_vld", 32'(disp_if.vld), 32'd1);
        end
        disp_if.rdy = 1'b1;
        wait_acc(65);
        repeat (20) step();
        chk("idle_vld", 32'(disp_if.vld), 32'd0);
        chk("idle_acc", 32'(acc_count), 32'd65);
        chk("resume_idx", 32'(digit_idx), 32'd1);
        enable = 1'b1;
        push_word();
        wait_acc(66);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Reset mid-transfer.
        disp_if.rdy = 1'b0;
        wait_vld();
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(disp_if.vld), 32'd0);
        chk("mid_rst_dat", 32'(disp_if.dat), 32'd0);
        chk("mid_rst_idx", 32'(digit_idx), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("sb_before_reset", 32'(exp_q.size()), 32'd0);
        step(); step();
        for (int i = 0; i < 8; i++) begin m_shadow[i] = 6'h10; m_active[i] = 6'h10; end
        push_idx = 0;
        push_frame();
        disp_if.rdy = 1'b1; spacing_on = 1'b1;
        rst = 1'b0;
        wait_acc(74);

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        chk("commit_done_timing", 32'(cd_bad), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/led7seg_scan_scheduler.md
Name: led7seg_scan_scheduler

Overview:
Multiplexed-display scheduler for the 8-digit 74HC595 seven-segment module. It owns a double-buffered 8-digit frame store written by application logic such as timers and counters. On a fixed per-digit slot tick it sequences digits 0..7 into the shift-register controller's 16-bit dat/vld/rdy port. Frame updates swap in atomically at frame boundaries, so the display never tears.

Parameters:
TICK_DIV, 15625, clk cycles per digit slot (125 MHz / 15625 = 8 kHz slot, 1 kHz frame); legal range >= 2
SEG_INV, 1, 1 = segment byte inverted (active-low segments)
DIG_INV, 0, 1 = digit-select byte inverted

Ports:
clk  in  1  system clock (125 MHz)
rst  in  1  asynchronous active-high reset
enable  in  1  1 = scanning runs; 0 = stop after the current transfer
wr_en  in  1  write one shadow-buffer digit
wr_addr  in  3  digit index to write, 0..7
wr_data  in  6  {dp, blank, bcd[3:0]}
commit  in  1  request shadow-to-active copy at the next frame boundary
commit_done  out  1  one-cycle pulse when the copy occurs
dat  out  16  {seg_byte[7:0], dig_byte[7:0]} to the 74HC595 controller
vld  out  1  dat valid
rdy  in  1  controller ready
digit_idx  out  3  index of the digit currently presented or next to present
frame_start  out  1  one-cycle pulse when the digit-0 word is accepted
overrun  out  1  sticky; set when a slot tick is lost

Behaviour:
- Reset (async, any state): shadow and active buffers all 6'b010000 (blank). vld=0, dat=0, digit_idx=0, tick counter=0.
- Also on reset: pending_tick=0, pending_commit=0, commit_done=0, frame_start=0, overrun=0. FSM goes to IDLE. A transfer in flight is abandoned; vld drops with reset.
- Tick counter counts 0..TICK_DIV-1 and wraps. tick = (cnt==TICK_DIV-1). The counter runs only while enable=1 and is held at 0 otherwise.
- FSM states:
  - IDLE: on enable=1, go to WAIT_TICK.
  - WAIT_TICK: on tick or pending_tick, clear pending_tick, register dat from active[digit_idx], assert vld, go to SEND. If enable=0, go to IDLE.
  - SEND: vld=1; dat and digit_idx stay stable until vld&rdy. On the accept cycle:
    - vld falls next cycle.
    - If digit_idx==0, pulse frame_start.
    - If digit_idx==7 and pending_commit=1, copy shadow to active, clear pending_commit, pulse commit_done.
    - Increment digit_idx mod 8.
    - Go to WAIT_TICK, or to IDLE if enable=0.
- Tick arriving while in SEND: set pending_tick. If pending_tick is already 1, set overrun; the extra tick is dropped. Only one pending tick is held.
- Latency: a tick in WAIT_TICK gives vld=1 on the next cycle. A pending tick in WAIT_TICK gives vld=1 on the next cycle.
- Writes: wr_en writes shadow[wr_addr] every cycle in any FSM state. Writes never touch active directly.
- commit sets pending_commit; repeated commits before the boundary collapse into one.
- Write and commit in the same cycle: the write is included in the copy.
- Write in the swap cycle: the copy uses the pre-write shadow value; the write lands in shadow only.
- Segment encoding (combinational), seg_byte = {dp,g,f,e,d,c,b,a} before inversion:
  - bcd 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F
  - bcd 10..15: 77,7C,39,5E,79,71 (A,b,C,d,E,F)
  - blank=1: 00, dp forced off
  - dp ORs bit 7
  - SEG_INV=1 inverts the whole byte.
- dig_byte = 1<<digit_idx; DIG_INV=1 inverts it.
- Disable mid-transfer: vld stays high until accepted (the handshake is never withdrawn), then IDLE. digit_idx is preserved, so scanning resumes from the next digit. pending_tick is cleared on entry to IDLE.

Test Plan:
- Reset, TICK_DIV=4, rdy=1, enable=1, all blank -> dat=16'hFF01, FF02, FF04 ... FF80 at 4-cycle spacing. frame_start pulses on each FF01 accept. overrun=0.
- Write addr0=0, addr3=7, then commit mid-frame -> display unchanged until digit 7 is accepted; commit_done pulses once. Next frame: dat=16'hC001 for digit 0 and 16'hF808 for digit 3; others FFxx.
- Hold rdy=0 for 10 cycles with vld=1 -> dat and digit_idx stable throughout. Tick at cycle 4 sets pending_tick; tick at cycle 8 sets overrun=1. After rdy=1, the next digit is presented 1 cycle after entering WAIT_TICK.
- wr_en addr5 data {dp=1,blank=0,bcd=8} in the same cycle as commit -> at the frame boundary, dat for digit 5 = 16'h0020 (SEG_INV=1).
- enable=0 while vld=1, rdy=0 -> vld held until rdy=1, then vld=0 indefinitely. Re-enabling resumes at digit_idx+1.
- Assert rst mid-SEND -> vld=0 immediately, overrun=0, and buffers return to blank. After release, scanning restarts at digit 0.
